// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding, ROM word layout, lane indices and limits for the note sequencer
package note_seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, RUN, DRAIN} state_t;
  localparam int LANE_LSB = 0;
  localparam int LANE_MSB = 2;
  localparam int END_BIT = 3;
  localparam int RED = 0;
  localparam int BLUE = 1;
  localparam int YELLOW = 2;
  localparam int COMBO_W = 8;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
endpackage

// File: rtl/note_hit_judge.sv
// note_hit_judge: judges one cycle of lane hits against the hit row
module note_hit_judge
  import note_seq_pkg::*;
(
  input  logic [2:0] hit_row,
  input  logic [2:0] hit,
  output logic [2:0] row_out,
  output logic [1:0] good_cnt,
  output logic       any_bad
);
  logic [2:0] good;
  // good hits clear their note; a hit on an empty lane is bad
  always_comb begin
    good = hit & hit_row;
    row_out = hit_row & ~hit;
    good_cnt = 2'(good[RED]) + 2'(good[BLUE]) + 2'(good[YELLOW]);
    any_bad = |(hit & ~hit_row);
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: fetches song notes, scrolls the 3-lane field, judges hits; optional pause via NOTE_SEQ_PAUSE_EN
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 8,
  parameter int SCORE_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           song_id,
  input  logic                 beat_tick,
  input  logic [2:0]           hit,
`ifdef NOTE_SEQ_PAUSE_EN
  input  logic                 pause,
`endif
  output logic [ADDR_W+1:0]    rom_addr,
  input  logic [3:0]           rom_data,
  output logic [3*DEPTH-1:0]   rows,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic                 busy,
  output logic                 finish
);
  state_t state;
  logic fph;
  logic [ADDR_W-1:0] idx;
  logic [1:0] sid;
  logic [3:0] next_word;
  logic act, tick, miss, end_word, any_bad;
  logic [2:0] hit_g, hr_clr, new_row;
  logic [1:0] good_cnt;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_nx;
  logic [COMBO_W:0] combo_sum;
  logic [COMBO_W-1:0] combo_nx;
  logic [3*DEPTH-1:0] shifted, judged;
`ifdef NOTE_SEQ_PAUSE_EN
  assign act = ~pause;
`else
  assign act = 1'b1;
`endif
  assign tick = beat_tick & act;
  assign hit_g = act ? hit : 3'b000;
  note_hit_judge u_judge (
    .hit_row (rows[3*DEPTH-1 -: 3]),
    .hit     (hit_g),
    .row_out (hr_clr),
    .good_cnt(good_cnt),
    .any_bad (any_bad)
  );
  // next field, score and combo for a RUN/DRAIN cycle; hits are resolved before any shift
  always_comb begin
    miss = tick & (|hr_clr);
    end_word = next_word[END_BIT] | (&idx);
    score_sum = {1'b0, score} + (SCORE_W+1)'(good_cnt);
    combo_sum = {1'b0, combo} + (COMBO_W+1)'(good_cnt);
    score_nx = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_nx = (any_bad | miss) ? '0 : combo_sum[COMBO_W] ? COMBO_MAX : combo_sum[COMBO_W-1:0];
    new_row = (state == RUN && !end_word) ? next_word[LANE_MSB:LANE_LSB] : 3'b000;
    shifted = {rows[3*DEPTH-4:0], new_row};
    judged = {hr_clr, rows[3*DEPTH-4:0]};
  end
  // song state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fph <= 1'b0;
      idx <= '0;
      sid <= '0;
      next_word <= '0;
      rom_addr <= '0;
      rows <= '0;
      score <= '0;
      combo <= '0;
      busy <= 1'b0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: if (start && song_id != 2'd0) begin
          rows <= '0;
          score <= '0;
          combo <= '0;
          idx <= '0;
          sid <= song_id;
          rom_addr <= {song_id, {ADDR_W{1'b0}}};
          fph <= 1'b0;
          busy <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          fph <= ~fph;
          if (fph) begin
            next_word <= rom_data;
            state <= RUN;
          end
        end
        default: if (act) begin
          if (state == DRAIN && rows == '0) begin
            finish <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            rows <= tick ? shifted : judged;
            score <= score_nx;
            combo <= combo_nx;
            if (tick && state == RUN) begin
              if (end_word) state <= DRAIN;
              else begin
                idx <= idx + ADDR_W'(1);
                rom_addr <= {sid, idx + ADDR_W'(1)};
                state <= FETCH;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: vector table, directed corner sequences and randomized runs against a queue-style model
module tb_note_sequencer;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, beat_tick = 1'b0;
  logic [1:0] song_id = '0;
  logic [2:0] hit = '0;
  logic [9:0] rom_addr;
  logic [3:0] rom_data = '0;
  logic [23:0] rows;
  logic [9:0] score;
  logic [7:0] combo;
  logic busy, finish;
  logic [3:0] rom [0:1023];
  int checks = 0, failures = 0;
  int ms, midx, msid, msc, mcb, m_good;
  bit m_bad, m_miss, m_last, mfin;
  logic [3:0] mnw;
  logic [2:0] mf [DEPTH];

  typedef struct {
    logic st; logic [1:0] sid; logic tk; logic [2:0] h;
    logic ebusy; logic [9:0] eaddr; logic [23:0] erows;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  note_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .song_id(song_id), .beat_tick(beat_tick),
    .hit(hit), .rom_addr(rom_addr), .rom_data(rom_data), .rows(rows), .score(score),
    .combo(combo), .busy(busy), .finish(finish)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    ms = 0; midx = 0; msid = 0; msc = 0; mcb = 0; mnw = '0; mfin = 0;
    foreach (mf[i]) mf[i] = '0;
  endtask

  function automatic bit m_empty();
    foreach (mf[i]) if (mf[i] != 0) return 0;
    return 1;
  endfunction

  function automatic logic [23:0] m_rows();
    logic [23:0] r;
    for (int i = 0; i < DEPTH; i++) r[3*i +: 3] = mf[i];
    return r;
  endfunction

  // model: 0 idle, 1/2 the two fetch cycles, 3 playing, 4 draining
  task automatic m_step();
    mfin = 0;
    if (ms == 0) begin
      if (start && song_id != 0) begin
        ms = 1; midx = 0; msid = song_id; msc = 0; mcb = 0;
        foreach (mf[i]) mf[i] = '0;
      end
    end else if (ms == 1) ms = 2;
    else if (ms == 2) begin
      mnw = rom[msid*256 + midx];
      ms = 3;
    end else if (ms == 4 && m_empty()) begin
      mfin = 1;
      ms = 0;
    end else begin
      m_good = $countones(hit & mf[DEPTH-1]);
      m_bad = |(hit & ~mf[DEPTH-1]);
      mf[DEPTH-1] = mf[DEPTH-1] & ~hit;
      m_miss = beat_tick && mf[DEPTH-1] != 0;
      m_last = mnw[3] || midx == 255;
      if (beat_tick) begin
        for (int i = DEPTH-1; i > 0; i--) mf[i] = mf[i-1];
        mf[0] = (ms == 3 && !m_last) ? mnw[2:0] : 3'b000;
      end
      msc = (msc + m_good > 1023) ? 1023 : msc + m_good;
      mcb = (m_bad || m_miss) ? 0 : ((mcb + m_good > 255) ? 255 : mcb + m_good);
      if (beat_tick && ms == 3) begin
        if (m_last) ms = 4;
        else begin
          midx++;
          ms = 1;
        end
      end
    end
  endtask

  task automatic mchk();
    chk("m_rows", rows, m_rows());
    chk("m_score", score, msc);
    chk("m_combo", combo, mcb);
    chk("m_busy", busy, ms != 0);
    chk("m_finish", finish, mfin);
    chk("m_addr", rom_addr, msid*256 + midx);
  endtask

  task automatic step(input logic st, input logic [1:0] sid, input logic tk, input logic [2:0] h);
    start = st; song_id = sid; beat_tick = tk; hit = h;
    m_step();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; beat_tick = 1'b0; hit = '0;
  endtask

  task automatic run_to_idle();
    for (int c = 0; c < 400 && busy; c++) step(0, 0, (c % 4) == 0, 0);
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int nfin, goods, sc0, cb0, gap;
    bit found;
    logic st, tk;
    logic [1:0] sid;
    logic [2:0] h;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[256] = 4'b0001; rom[257] = 4'b0010; rom[258] = 4'b1000;
    for (int i = 0; i < 6; i++) rom[768+i] = 4'b0001;
    rom[774] = 4'b0011;
    rom[783] = 4'b1000;
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 10'h000, 24'h000000};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 10'h000, 24'h000000};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 3'd0, 1'b1, 10'h100, 24'h000000};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 3'd0, 1'b1, 10'h100, 24'h000000};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 10'h100, 24'h000000};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 3'd0, 1'b1, 10'h101, 24'h000001};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 3'd0, 1'b1, 10'h101, 24'h000001};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 10'h101, 24'h000001};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 3'd0, 1'b1, 10'h102, 24'h00000A};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 10'h102, 24'h00000A};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 10'h102, 24'h00000A};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 3'd0, 1'b1, 10'h102, 24'h000050};
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_rows", rows, 0);
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].sid, tbl[i].tk, tbl[i].h);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_rows", i), rows, tbl[i].erows);
    end
    nfin = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      step(0, 0, (c % 4) == 0, 0);
      if (c == 20) chk("a_combo_tick9", combo, 0);
      if (finish) begin
        nfin++;
        chk("a_busy_at_finish", busy, 0);
      end
    end
    chk("a_done", busy, 0);
    chk("a_score", score, 0);
    repeat (8) begin
      step(0, 0, 0, 0);
      if (finish) nfin++;
    end
    chk("a_finish_count", nfin, 1);
    step(1, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    found = 0;
    for (int p = 0; p < 20 && !found; p++) begin
      step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      if (rows[23:21] == 3'b001) begin
        step(0, 0, 0, 3'b001);
        found = 1;
        chk("b_score", score, 1);
        chk("b_combo", combo, 1);
        chk("b_cleared", rows[23:21], 0);
      end else step(0, 0, 0, 0);
    end
    chk("b_found", found, 1);
    run_to_idle();
    step(1, 3, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    goods = 0; found = 0;
    for (int p = 0; p < 30 && !found; p++) begin
      step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      if (rows[23:21] == 3'b001 && goods < 5) begin
        step(0, 0, 0, 3'b001);
        goods++;
      end else if (rows[23:21] == 3'b001) begin
        chk("c_combo5", combo, 5);
        sc0 = score;
        step(0, 0, 0, 3'b100);
        found = 1;
        chk("c_combo_cleared", combo, 0);
        chk("c_score_held", score, sc0);
        chk("c_row_kept", rows[21], 1);
      end else step(0, 0, 0, 0);
    end
    chk("c_found", found, 1);
    found = 0;
    for (int p = 0; p < 20 && !found; p++) begin
      if (rows[23:21] == 3'b011) begin
        sc0 = score; cb0 = combo;
        step(0, 0, 1, 3'b011);
        found = 1;
        chk("d_score", score, sc0 + 2);
        chk("d_combo", combo, cb0 + 2);
        chk("d_score7", score, 7);
      end else begin
        step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      end
    end
    chk("d_found", found, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("e_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("e_rows", rows, 0);
    chk("e_score", score, 0);
    chk("e_combo", combo, 0);
    chk("e_busy", busy, 0);
    chk("e_finish", finish, 0);
    chk("e_addr", rom_addr, 0);
    @(posedge clk); @(negedge clk);
    chk("e_no_finish_in_rst", finish, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("e_no_finish_after", finish, 0);
    step(1, 1, 0, 0);
    chk("e_restart_addr", rom_addr, 10'h100);
    run_to_idle();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) rom[512+i] = {1'b0, 3'($urandom)};
      if (r == 1) rom[512] = 4'b1000;
      if (r >= 2) rom[512 + $urandom_range(1, 30)] = {1'b1, 3'($urandom)};
      step(1, 2, 0, 0);
      mchk();
      gap = 0;
      for (int c = 0; c < 4000 && busy; c++) begin
        tk = (gap == 0);
        gap = tk ? $urandom_range(3, 6) : gap - 1;
        h = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        st = ($urandom_range(0, 15) == 0);
        sid = 2'($urandom);
        step(st, sid, tk, h);
        mchk();
      end
      chk($sformatf("rnd%0d_done", r), busy, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Controls the rhythm game while the game state machine is in PLAY.
- Fetches note words for the selected song from a synchronous note ROM and scrolls them down a DEPTH-row, 3-lane falling-note field shown on the LED matrix.
- Judges debounced red/blue/yellow hit pulses against the bottom (hit) row and keeps score and combo.
- Pulses finish, which drives the state machine's PLAY -> FINISH transition.

Parameters:
- DEPTH, 8: rows in the note field; row DEPTH-1 is the hit row.
- ADDR_W, 8: note index width per song.
- SCORE_W, 10: score width; score saturates at its maximum.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins song song_id
- song_id  in  2  song selection; 0 is invalid
- beat_tick  in  1  one-cycle scroll strobe
- hit  in  3  one-cycle debounced pulses; bit0 red, bit1 blue, bit2 yellow
- rom_addr  out  2+ADDR_W  registered address, equal to {song_id, idx}
- rom_data  in  4  valid one cycle after rom_addr changes; [2:0] lane mask, [3] end marker
- rows  out  3*DEPTH  note field; bits [3i+2:3i] are row i, row 0 is the top
- score  out  SCORE_W  good-hit count
- combo  out  8  consecutive good hits, saturates at 255
- busy  out  1  high in FETCH, RUN and DRAIN
- finish  out  1  one-cycle pulse when the song completes

Behaviour:
Reset values:
- state=IDLE; rows, score, combo, idx, rom_addr, next_word, finish and busy are all 0.
- Assertion of rst_n mid-song returns everything to these values immediately. No finish pulse is generated.

States and transitions:
- IDLE: on start with song_id!=0, clear rows, score, combo and idx, latch song_id, and go to FETCH. Start with song_id=0 is ignored. Start is ignored in every state other than IDLE.
- FETCH (2 cycles): cycle 1 drives rom_addr. Cycle 2 captures rom_data into next_word and goes to RUN. A beat_tick that arrives during FETCH is dropped. Tick spacing is at least 4 cycles by system contract.
- RUN: on beat_tick:
  - Shift the field: row[i+1] <= row[i]; row[0] <= next_word[2:0].
  - If the old hit row still has set bits (a miss), clear combo.
  - If next_word[3]=1, or idx equals 2^ADDR_W-1, go to DRAIN; that end word's lane bits are not shifted in.
  - Otherwise increment idx and go to FETCH.
- DRAIN:
  - On beat_tick, shift zeros into row 0, with the same miss rule as RUN.
  - In any cycle where all rows are 0, pulse finish for 1 cycle and go to IDLE. Score and combo are held until the next start.

Hit judging (RUN and DRAIN only; ignored in IDLE and FETCH):
- Each lane k is judged independently against the hit row before any shift in the same cycle.
- hit[k]=1 with row[DEPTH-1][k]=1 is a good hit: the bit is cleared.
- hit[k]=1 with row[DEPTH-1][k]=0 is a bad hit.
- score += number of good hits, saturating.
- combo: cleared if any bad hit or miss occurs this cycle; otherwise combo += number of good hits, saturating.
- hit and beat_tick in the same cycle: bits hit this cycle are cleared before the shift and do not count as misses.

Empty song: an end marker at idx 0 gives FETCH -> RUN. The first tick enters DRAIN, and finish follows on the next cycle because the field is empty.

Optional Feature:
NOTE_SEQ_PAUSE_EN
- Defined: adds input port pause (1 bit). While pause=1, beat_tick and hit are ignored and all registers hold. FETCH still completes.
- Undefined: no pause port; behaviour is exactly as above.

Decomposition:
Shared package note_seq_pkg holds:
- the state enum {IDLE, FETCH, RUN, DRAIN};
- ROM word field constants LANE_LSB=0, LANE_MSB=2, END_BIT=3;
- lane indices RED=0, BLUE=1, YELLOW=2;
- the saturation limits.

One sub-module, note_hit_judge (combinational):
- Inputs: hit row and hit vector.
- Outputs: cleared hit row, good-hit count (0-3), any_bad.

Test Plan:
- Song 1 ROM = {3'b001, 3'b010, end}, DEPTH=8, no hits. After 9 ticks, combo=0 and score=0; finish pulses exactly once after the field empties; busy drops in the same cycle.
- Same song, hit=3'b001 pulsed when rows[23:21]=3'b001. Required: score=1, combo=1, and that bit is cleared on the following cycle.
- hit=3'b100 with hit row 3'b001. Required: combo 5 -> 0; score unchanged; row bit stays set.
- hit=3'b011 together with beat_tick on hit row 3'b011. Required: score +2, combo +2, no miss recorded.
- start with song_id=0 -> stays IDLE, busy=0. A start while busy is ignored, and rom_addr keeps the original song_id.
- rst_n low mid-RUN with score=7. Required: every output is 0 at once, no finish, and the next start begins from idx 0.
